// File: rtl/buzz_pkg.sv
// Shared types and constants for the music-buzzer note arbiter.
// Default half-periods assume the 50 MHz board clock.
package buzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [1:0] NOTE_C4  = 2'd0;
    localparam logic [1:0] NOTE_E4  = 2'd1;
    localparam logic [1:0] NOTE_AB4 = 2'd2;
    localparam logic [1:0] NOTE_C5  = 2'd3;

    localparam int DEF_HALF_C4    = 95556;
    localparam int DEF_HALF_E4    = 75843;
    localparam int DEF_HALF_AB4   = 60197;
    localparam int DEF_HALF_C5    = 47778;
    localparam int DEF_GAP_CYCLES = 500000;
    localparam int DEF_CNT_W      = 20;

    // Highest set bit wins, so simultaneous presses favour the higher note.
    function automatic logic [1:0] top_idx(input logic [3:0] v);
        top_idx = NOTE_C4;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) top_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Shared counter: square-wave divider while playing, silence timer during a gap.
// clr zeroes both the count and the tone phase.
module tone_divider
    import buzz_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tgl_en,
    input  logic [CNT_W-1:0] half,
    output logic             tone,
    output logic             at_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    assign at_end = (cnt_q == half - CNT_W'(1));
    assign tone   = tone_q;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tone_d = tone_q;
        if (clr) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (at_end) begin
            cnt_d = '0;
            if (tgl_en) tone_d = ~tone_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

endmodule

// File: rtl/buzz_note_arbiter.sv
// Last-pressed-wins note arbiter for four buttons, with a silence gap
// inserted on every note change before the new tone starts.
module buzz_note_arbiter
    import buzz_pkg::*;
#(
    parameter int HALF_C4    = DEF_HALF_C4,
    parameter int HALF_E4    = DEF_HALF_E4,
    parameter int HALF_AB4   = DEF_HALF_AB4,
    parameter int HALF_C5    = DEF_HALF_C5,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       mute,
    output logic       buzzer,
    output logic [1:0] note_idx,
    output logic       playing
);

    localparam logic [3:0][CNT_W-1:0] HALF_TBL = {
        CNT_W'(HALF_C5), CNT_W'(HALF_AB4), CNT_W'(HALF_E4), CNT_W'(HALF_C4)
    };

    state_e      state_q, state_d;
    logic [3:0]  btn_q, rise;
    logic [1:0]  note_q, note_d, pend_q, pend_d;
    logic        playing_q, playing_d;
    logic        cand_chg, cand_none;
    logic [1:0]  cand_idx;
    logic [CNT_W-1:0] half_sel;
    logic        tone, at_end, clr;

    assign rise = btn & ~btn_q;

    // A fresh press beats everything; otherwise losing the selected (or
    // pending) note falls back to the highest note still held.
    always_comb begin
        cand_chg  = 1'b0;
        cand_idx  = top_idx(btn);
        cand_none = (btn == 4'b0);
        if (rise != 4'b0) begin
            cand_chg  = 1'b1;
            cand_idx  = top_idx(rise);
            cand_none = 1'b0;
        end else if (!btn[note_q] || (state_q == ST_GAP && !btn[pend_q])) begin
            cand_chg = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cand_chg && !cand_none) begin
                    state_d = ST_PLAY;
                    note_d  = cand_idx;
                end
            end
            ST_PLAY: begin
                if (cand_chg && cand_none) begin
                    state_d = ST_IDLE;
                end else if (cand_chg && cand_idx != note_q) begin
                    state_d = ST_GAP;
                    pend_d  = cand_idx;
                end
            end
            ST_GAP: begin
                if (cand_chg && cand_none) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cand_chg) pend_d = cand_idx;
                    if (at_end) begin
                        state_d = ST_PLAY;
                        note_d  = pend_d;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        playing_d = (state_d == ST_PLAY);
    end

    // Counter restarts on every state change and sits at zero in IDLE.
    assign clr      = (state_d != state_q) || (state_q == ST_IDLE);
    assign half_sel = (state_q == ST_GAP) ? CNT_W'(GAP_CYCLES) : HALF_TBL[note_q];

    tone_divider #(.CNT_W(CNT_W)) u_div (
        .clk    (clk_50MHz),
        .rst_n  (reset),
        .clr    (clr),
        .tgl_en (state_q == ST_PLAY),
        .half   (half_sel),
        .tone   (tone),
        .at_end (at_end)
    );

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            btn_q     <= 4'b0;
            note_q    <= NOTE_C4;
            pend_q    <= NOTE_C4;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn;
            note_q    <= note_d;
            pend_q    <= pend_d;
            playing_q <= playing_d;
        end
    end

    assign buzzer   = tone & ~mute;
    assign note_idx = note_q;
    assign playing  = playing_q;

endmodule

// File: tb/tb_buzz_note_arbiter.sv
// Directed vector bench for buzz_note_arbiter with short half-periods and gap.
module tb_buzz_note_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       mute = 1'b0;
    logic       buzzer;
    logic [1:0] note_idx;
    logic       playing;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] btn;
        logic       mute;
        logic       bz;
        logic [1:0] note;
        logic       pl;
    } vec_t;

    vec_t vecs[$];

    buzz_note_arbiter #(
        .HALF_C4(4), .HALF_E4(5), .HALF_AB4(6), .HALF_C5(7),
        .GAP_CYCLES(3), .CNT_W(8)
    ) dut (
        .clk_50MHz (clk),
        .reset     (rst_n),
        .btn       (btn),
        .mute      (mute),
        .buzzer    (buzzer),
        .note_idx  (note_idx),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [3:0] b, input logic m, input logic bz,
                       input logic [1:0] n, input logic pl, input int rep);
        vec_t v;
        v.btn = b; v.mute = m; v.bz = bz; v.note = n; v.pl = pl;
        for (int r = 0; r < rep; r++) vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] exp);
        logic [3:0] act;
        act = {buzzer, note_idx, playing};
        total++;
        if (act !== exp)
            $display("FAIL %s got {bz,note,pl}=%b want %b", nm, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each record: inputs applied before an edge, outputs expected after it.
        add(4'b0001, 0, 0, 0, 1, 4);  // press C4 from IDLE
        add(4'b0001, 0, 1, 0, 1, 4);
        add(4'b0001, 0, 0, 0, 1, 2);
        add(4'b0101, 0, 0, 0, 0, 3);  // Ab4 pressed: 3-cycle gap
        add(4'b0101, 0, 0, 2, 1, 6);
        add(4'b0101, 0, 1, 2, 1, 2);
        add(4'b0101, 1, 0, 2, 1, 2);  // muted mid half-period
        add(4'b0101, 0, 1, 2, 1, 2);  // phase kept running
        add(4'b0101, 0, 0, 2, 1, 2);
        add(4'b0001, 0, 0, 2, 0, 3);  // Ab4 released: gap back to C4
        add(4'b0001, 0, 0, 0, 1, 4);
        add(4'b0001, 0, 1, 0, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 1);  // release all
        add(4'b1010, 0, 0, 3, 1, 7);  // simultaneous E4+C5: C5 wins
        add(4'b1010, 0, 1, 3, 1, 2);
        add(4'b0010, 0, 0, 3, 0, 3);  // C5 released: fall back to held E4
        add(4'b0010, 0, 0, 1, 1, 5);
        add(4'b0010, 0, 1, 1, 1, 1);
        add(4'b0000, 0, 0, 1, 0, 1);  // E4 released: IDLE next cycle
        add(4'b0001, 0, 0, 0, 1, 1);
        add(4'b0011, 0, 0, 0, 0, 1);  // E4 pressed -> gap
        add(4'b0010, 0, 0, 0, 0, 1);
        add(4'b0000, 0, 0, 0, 0, 3);  // released inside gap: never plays
        add(4'b0001, 0, 0, 0, 1, 1);
        add(4'b0101, 0, 0, 0, 0, 1);  // enter gap for reset test

        #2;
        chk("reset_state", 4'b0000);
        step();
        chk("reset_held", 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle%0d", i), 4'b0000);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            btn  = vecs[i].btn;
            mute = vecs[i].mute;
            step();
            chk($sformatf("vec%0d", i), {vecs[i].bz, vecs[i].note, vecs[i].pl});
        end

        // Async reset in mid-gap with Ab4 still held.
        btn = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold%0d", i), 4'b0000);
        end
        rst_n = 1'b1;
        step();
        chk("rst_rel_play", 4'b0101);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_ab4_lo%0d", i), 4'b0101);
        end
        step();
        chk("rst_ab4_hi", 4'b1101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
